// File: rtl/periph_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : periph_pkg
//  Description : Address map, register bit positions and the STATUS word
//                layout shared by the peripheral bus block.
//  Revision    : 1.0 - initial release
// ============================================================================
package periph_pkg;

    // Block base; the block decodes the low byte of the address as offset.
    localparam logic [31:0] c_BASE_ADDR      = 32'h4000_0000;

    // Register offsets. Timer 0 is aliased at the legacy 0x00/0x04/0x08.
    localparam logic [7:0]  c_OFF_TH         = 8'h00;
    localparam logic [7:0]  c_OFF_TL         = 8'h04;
    localparam logic [7:0]  c_OFF_TCON       = 8'h08;
    localparam logic [7:0]  c_OFF_LED        = 8'h0C;
    localparam logic [7:0]  c_OFF_DIGI       = 8'h14;
    localparam logic [7:0]  c_OFF_TX_DATA    = 8'h18;
    localparam logic [7:0]  c_OFF_RX_DATA    = 8'h1C;
    localparam logic [7:0]  c_OFF_STATUS     = 8'h20;
    localparam logic [7:0]  c_OFF_IRQ_STAT   = 8'h24;
    localparam logic [7:0]  c_OFF_UART_CTRL  = 8'h28;
    localparam logic [7:0]  c_TIMER_BASE     = 8'h80;
    localparam logic [7:0]  c_TIMER_STRIDE   = 8'h10;

    // TCON bits: enable, interrupt enable, sticky overflow flag.
    localparam int c_TCON_EN   = 0;
    localparam int c_TCON_IE   = 1;
    localparam int c_TCON_FLAG = 2;

    // UART_CTRL bits; flush is a write-only strobe.
    localparam int c_CTRL_RX_IE = 0;
    localparam int c_CTRL_TX_IE = 1;
    localparam int c_CTRL_FLUSH = 2;

    // STATUS word layout, MSB first.
    typedef struct packed {
        logic [7:0]  tx_count;
        logic [7:0]  rx_count;
        logic [11:0] rsvd;
        logic        tx_empty;
        logic        rx_ovf;
        logic        rx_nonempty;
        logic        tx_full;
    } status_t;

    // Offset of a register inside timer channel idx.
    function automatic logic [7:0] timer_off(input int idx, input logic [7:0] reg_off);
        return c_TIMER_BASE + (8'(idx) * c_TIMER_STRIDE) + reg_off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/periph_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : periph_fifo
//  Description : 8-bit synchronous FIFO with flush; a pop frees an entry in
//                the same cycle so push+pop at full is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module periph_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [7:0]               i_din,
    output logic [7:0]               o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointer and occupancy update; flush overrides any push or pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible behind the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/peripheral_bus_v2.sv
`default_nettype none
// ============================================================================
//  Module      : peripheral_bus_v2
//  Description : Memory-mapped timers, LED/7-seg registers and byte UART
//                FIFOs with a single registered interrupt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module peripheral_bus_v2 #(
    parameter int N_TIMERS   = 2,
    parameter int TIMER_W    = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int LED_W      = 8,
    parameter int DIGI_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [LED_W-1:0]  led,
    output logic [DIGI_W-1:0] digi,
    output logic              irqout,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid
);

    import periph_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]         w_off;
    logic               w_rd_en, w_wr_en;
    logic               w_flush, w_tx_push, w_tx_pop, w_rx_pop, w_rx_drop, w_status_rd;
    logic               w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [CW-1:0]      w_tx_count, w_rx_count;
    logic [7:0]         w_rx_dout;
    logic               w_rx_pend, w_tx_pend;
    logic [TIMER_W-1:0] w_th   [N_TIMERS];
    logic [TIMER_W-1:0] w_tl   [N_TIMERS];
    logic [2:0]         w_tcon [N_TIMERS];
    logic [N_TIMERS-1:0] w_tflag;
    status_t            w_status;
    logic [31:0]        w_irq_stat;
    logic [31:0]        w_rdata;

    logic [LED_W-1:0]   r_led;
    logic [DIGI_W-1:0]  r_digi;
    logic               r_rx_ie, r_tx_ie, r_rx_ovf, r_irq;

    assign w_off       = addr[7:0];
    assign w_rd_en     = rd & (addr[31:8] == c_BASE_ADDR[31:8]);
    assign w_wr_en     = wr & (addr[31:8] == c_BASE_ADDR[31:8]);
    assign w_flush     = w_wr_en && (w_off == c_OFF_UART_CTRL) && wdata[c_CTRL_FLUSH];
    assign w_tx_push   = w_wr_en && (w_off == c_OFF_TX_DATA);
    assign w_tx_pop    = ~w_tx_empty & tx_ready;
    assign w_rx_pop    = w_rd_en && (w_off == c_OFF_RX_DATA) && ~w_rx_empty;
    assign w_status_rd = w_rd_en && (w_off == c_OFF_STATUS);
    // A byte arriving at a full FIFO is lost unless a pop frees room this cycle.
    assign w_rx_drop   = rx_valid & w_rx_full & ~w_rx_pop & ~w_flush;
    assign w_rx_pend   = r_rx_ie & ~w_rx_empty;
    assign w_tx_pend   = r_tx_ie & w_tx_empty;

    assign rdata    = w_rdata;
    assign led      = r_led;
    assign digi     = r_digi;
    assign irqout   = r_irq;
    assign tx_valid = ~w_tx_empty;

    periph_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .i_push(w_tx_push), .i_pop(w_tx_pop), .i_flush(w_flush),
        .i_din(wdata[7:0]), .o_dout(tx_data), .o_full(w_tx_full), .o_empty(w_tx_empty),
        .o_count(w_tx_count)
    );

    periph_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .i_push(rx_valid), .i_pop(w_rx_pop), .i_flush(w_flush),
        .i_din(rx_data), .o_dout(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty),
        .o_count(w_rx_count)
    );

    for (genvar gi = 0; gi < N_TIMERS; gi++) begin : g_timer
        logic [TIMER_W-1:0] r_th, r_tl;
        logic [2:0]         r_tcon;
        logic               w_hit_th, w_hit_tl, w_hit_tcon, w_wrap;

        assign w_hit_th   = w_wr_en && ((w_off == timer_off(gi, c_OFF_TH)) ||
                                        (gi == 0 && w_off == c_OFF_TH));
        assign w_hit_tl   = w_wr_en && ((w_off == timer_off(gi, c_OFF_TL)) ||
                                        (gi == 0 && w_off == c_OFF_TL));
        assign w_hit_tcon = w_wr_en && ((w_off == timer_off(gi, c_OFF_TCON)) ||
                                        (gi == 0 && w_off == c_OFF_TCON));
        assign w_wrap     = r_tcon[c_TCON_EN] && (r_tl == '1);

        // Reload timer; bus writes to TL/TCON take precedence over counting.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_th   <= '0;
                r_tl   <= '0;
                r_tcon <= '0;
            end else begin
                if (w_hit_th) r_th <= wdata[TIMER_W-1:0];
                if (w_hit_tl)                 r_tl <= wdata[TIMER_W-1:0];
                else if (r_tcon[c_TCON_EN])   r_tl <= w_wrap ? r_th : r_tl + TIMER_W'(1);
                if (w_hit_tcon)                          r_tcon <= wdata[2:0];
                else if (w_wrap && r_tcon[c_TCON_IE])    r_tcon[c_TCON_FLAG] <= 1'b1;
            end
        end

        assign w_th[gi]    = r_th;
        assign w_tl[gi]    = r_tl;
        assign w_tcon[gi]  = r_tcon;
        assign w_tflag[gi] = r_tcon[c_TCON_FLAG];
    end

    // Output registers, UART enables, sticky overflow and the interrupt line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led    <= '0;
            r_digi   <= '0;
            r_rx_ie  <= 1'b0;
            r_tx_ie  <= 1'b0;
            r_rx_ovf <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_en && w_off == c_OFF_LED)  r_led  <= wdata[LED_W-1:0];
            if (w_wr_en && w_off == c_OFF_DIGI) r_digi <= wdata[DIGI_W-1:0];
            if (w_wr_en && w_off == c_OFF_UART_CTRL) begin
                r_rx_ie <= wdata[c_CTRL_RX_IE];
                r_tx_ie <= wdata[c_CTRL_TX_IE];
            end
            // A fresh overflow beats the clear-on-read of STATUS.
            if (w_rx_drop)        r_rx_ovf <= 1'b1;
            else if (w_status_rd) r_rx_ovf <= 1'b0;
            r_irq <= (|w_tflag) | w_rx_pend | w_tx_pend;
        end
    end

    // Assemble the STATUS and IRQ_STAT read words.
    always_comb begin
        w_status             = '0;
        w_status.tx_full     = w_tx_full;
        w_status.rx_nonempty = ~w_rx_empty;
        w_status.rx_ovf      = r_rx_ovf;
        w_status.tx_empty    = w_tx_empty;
        w_status.rx_count    = 8'(w_rx_count);
        w_status.tx_count    = 8'(w_tx_count);
        w_irq_stat                 = '0;
        w_irq_stat[N_TIMERS-1:0]   = w_tflag;
        w_irq_stat[N_TIMERS]       = w_rx_pend;
        w_irq_stat[N_TIMERS+1]     = w_tx_pend;
    end

    // Combinational read mux; zero when idle or unmapped.
    always_comb begin
        w_rdata = '0;
        if (w_rd_en) begin
            case (w_off)
                c_OFF_TH:        w_rdata = 32'(w_th[0]);
                c_OFF_TL:        w_rdata = 32'(w_tl[0]);
                c_OFF_TCON:      w_rdata = 32'(w_tcon[0]);
                c_OFF_LED:       w_rdata = 32'(r_led);
                c_OFF_DIGI:      w_rdata = 32'(r_digi);
                c_OFF_RX_DATA:   w_rdata = w_rx_empty ? 32'h0 : 32'(w_rx_dout);
                c_OFF_STATUS:    w_rdata = w_status;
                c_OFF_IRQ_STAT:  w_rdata = w_irq_stat;
                c_OFF_UART_CTRL: w_rdata = {30'h0, r_tx_ie, r_rx_ie};
                default:         w_rdata = '0;
            endcase
            for (int i = 0; i < N_TIMERS; i++) begin
                if (w_off == timer_off(i, c_OFF_TH))   w_rdata = 32'(w_th[i]);
                if (w_off == timer_off(i, c_OFF_TL))   w_rdata = 32'(w_tl[i]);
                if (w_off == timer_off(i, c_OFF_TCON)) w_rdata = 32'(w_tcon[i]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_bus_v2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peripheral_bus_v2
//  Description : Directed scoreboard bench for peripheral_bus_v2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_bus_v2;

    localparam logic [31:0] A_TH0_AL = 32'h4000_0000;
    localparam logic [31:0] A_TCON_AL= 32'h4000_0008;
    localparam logic [31:0] A_LED    = 32'h4000_000C;
    localparam logic [31:0] A_DIGI   = 32'h4000_0014;
    localparam logic [31:0] A_TX     = 32'h4000_0018;
    localparam logic [31:0] A_RX     = 32'h4000_001C;
    localparam logic [31:0] A_STAT   = 32'h4000_0020;
    localparam logic [31:0] A_IRQ    = 32'h4000_0024;
    localparam logic [31:0] A_CTRL   = 32'h4000_0028;
    localparam logic [31:0] A_TH0    = 32'h4000_0080;
    localparam logic [31:0] A_TL0    = 32'h4000_0084;
    localparam logic [31:0] A_TCON0  = 32'h4000_0088;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [7:0]  tx_model[$];
    logic [7:0]  rx_model[$];

    peripheral_bus_v2 #(
        .N_TIMERS(2), .TIMER_W(32), .FIFO_DEPTH(16), .LED_W(8), .DIGI_W(12)
    ) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .led(led), .digi(digi), .irqout(irqout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic score(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", t, obs, e);
        end
    endtask

    task automatic check_now(input string tag, input logic [31:0] obs, input logic [31:0] e);
        expect_val(tag, e);
        score(obs);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string tag);
        @(negedge clk);
        rd = 1'b1; addr = a;
        expect_val(tag, e);
        #1 score(rdata);
        @(posedge clk);
        #1 rd = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1 wr = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] b);
        if (tx_model.size() < 16) tx_model.push_back(b);
        bus_write(A_TX, {24'h0, b});
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b;
        if (rx_model.size() < 16) rx_model.push_back(b);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check_now("rst_led", 32'(led), 32'h0);
        check_now("rst_digi", 32'(digi), 32'h0);
        check_now("rst_irq", 32'(irqout), 32'h0);
        check_now("rst_txv", 32'(tx_valid), 32'h0);
        check_now("rdata_idle", rdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Simple registers, truncation and unmapped space
        bus_write(A_LED, 32'hFFFF_FFA5);
        bus_write(A_DIGI, 32'hFFFF_1234);
        bus_write(32'h4000_0030, 32'h1234_5678);
        bus_read(A_LED, 32'h0000_00A5, "led_rb");
        bus_read(A_DIGI, 32'h0000_0234, "digi_rb");
        check_now("led_port", 32'(led), 32'hA5);
        bus_read(32'h4000_0030, 32'h0, "unmapped");
        bus_read(32'h5000_000C, 32'h0, "out_of_base");
        bus_read(A_TX, 32'h0, "txdata_rd");

        // Timer 0 alias, reload and sticky flag
        bus_write(A_TH0_AL, 32'h0000_0055);
        bus_read(A_TH0, 32'h0000_0055, "th_alias");
        bus_write(A_TH0, 32'hFFFF_FFFD);
        bus_write(A_TL0, 32'hFFFF_FFFE);
        bus_write(A_TCON0, 32'h3);
        @(posedge clk); @(posedge clk); #1;
        check_now("irq_lag", 32'(irqout), 32'h0);
        rd = 1'b1; addr = A_TL0;
        expect_val("tl_reload", 32'hFFFF_FFFD);
        #1 score(rdata);
        addr = A_TCON0;
        expect_val("tcon_flag", 32'h7);
        #1 score(rdata);
        rd = 1'b0;
        @(posedge clk); #1;
        check_now("irq_timer", 32'(irqout), 32'h1);
        bus_write(A_TCON0, 32'h0);
        @(posedge clk); #1;
        check_now("irq_timer_clr", 32'(irqout), 32'h0);
        bus_read(A_TCON_AL, 32'h0, "tcon_alias");

        // TX FIFO fill with overflow drop, then drain
        for (int k = 0; k < 17; k++) tx_write(8'(k));
        bus_read(A_STAT, 32'h1000_0001, "tx_full_stat");
        for (int n = 0; n < 40 && tx_model.size() > 0; n++) begin
            @(negedge clk);
            tx_ready = 1'b1;
            if (tx_valid) begin
                expect_val("tx_data", {24'h0, tx_model.pop_front()});
                score({24'h0, tx_data});
            end
        end
        check_now("tx_drain_left", tx_model.size(), 32'h0);
        @(negedge clk);
        check_now("tx_valid_end", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;
        bus_read(A_STAT, 32'h0000_0008, "tx_empty_stat");

        // RX overflow, clear-on-read, ordered drain
        for (int k = 0; k < 17; k++) rx_pulse(8'hA0 + 8'(k));
        bus_read(A_STAT, 32'h0010_000E, "rx_ovf_set");
        bus_read(A_STAT, 32'h0010_000A, "rx_ovf_clr");
        for (int k = 0; k < 16; k++) bus_read(A_RX, {24'h0, rx_model.pop_front()}, "rx_data");
        bus_read(A_RX, 32'h0, "rx_empty_rd");

        // Simultaneous push and pop at full
        for (int k = 0; k < 16; k++) rx_pulse(8'h30 + 8'(k));
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h77; rd = 1'b1; addr = A_RX;
        expect_val("rx_pop_push", {24'h0, rx_model.pop_front()});
        rx_model.push_back(8'h77);
        #1 score(rdata);
        @(posedge clk);
        #1 begin rx_valid = 1'b0; rd = 1'b0; end
        bus_read(A_STAT, 32'h0010_000A, "rx_full_no_ovf");

        // Flush with both FIFOs half full
        for (int k = 0; k < 8; k++) bus_read(A_RX, {24'h0, rx_model.pop_front()}, "rx_data2");
        for (int k = 0; k < 8; k++) tx_write(8'h60 + 8'(k));
        bus_read(A_STAT, 32'h0808_0002, "half_stat");
        bus_write(A_CTRL, 32'h4);
        tx_model.delete();
        rx_model.delete();
        bus_read(A_STAT, 32'h0000_0008, "flush_stat");

        // RX interrupt
        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, 32'h1, "ctrl_rb");
        rx_pulse(8'h5A);
        @(posedge clk); #1;
        check_now("irq_rx", 32'(irqout), 32'h1);
        bus_read(A_IRQ, 32'h4, "irq_stat");
        bus_read(A_RX, 32'h5A, "rx_irq_byte");
        @(posedge clk); #1;
        check_now("irq_rx_clr", 32'(irqout), 32'h0);

        // Reset in the middle of queued TX traffic
        for (int k = 0; k < 5; k++) tx_write(8'h90 + 8'(k));
        @(negedge clk);
        check_now("txv_before_rst", 32'(tx_valid), 32'h1);
        #2 reset = 1'b0;
        #1 check_now("txv_async_rst", 32'(tx_valid), 32'h0);
        tx_model.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus_read(A_STAT, 32'h0000_0008, "post_rst_stat");
        check_now("post_rst_led", 32'(led), 32'h0);
        check_now("post_rst_digi", 32'(digi), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/peripheral_bus_v2.md
Name: peripheral_bus_v2

Overview:
Memory-mapped peripheral block on the pipeline CPU data bus, base 0x40000000. It provides N_TIMERS reload timers, LED and 7-segment output registers, and a byte-level UART interface with RX/TX FIFOs. Interrupt sources are aggregated into one irqout. The UART bit serialiser/deserialiser stays external; this block talks to it over byte valid/ready handshakes. Legacy offsets 0x00–0x20 keep their map and meaning; the FIFOs add depth and an RX overflow flag.

Parameters:
N_TIMERS, 2, number of timer channels (1..4)
TIMER_W, 32, timer TH/TL width (8..32)
FIFO_DEPTH, 16, RX and TX FIFO entries (power of 2, 2..128)
LED_W, 8, LED register width
DIGI_W, 12, 7-segment register width

Ports:
clk  in  1  system clock; only clock
reset  in  1  asynchronous, active-low reset
rd  in  1  bus read strobe
wr  in  1  bus write strobe
addr  in  32  byte address
wdata  in  32  write data
rdata  out  32  read data; combinational
led  out  LED_W  LED register
digi  out  DIGI_W  7-segment register
irqout  out  1  aggregated interrupt, level
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  transmitter accepts byte this cycle
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle pulse, rx_data valid

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. Under reset all registers, FIFO pointers and sticky flags clear, and led, digi, tx_valid and irqout go to 0.
- Register map (offset from base):
  - Timer i: TH at 0x80+0x10*i, TL at +4, TCON at +8. Timer 0 is also aliased at 0x00/0x04/0x08.
  - 0x0C LED; 0x14 DIGI.
  - 0x18 TX_DATA: write pushes wdata[7:0]; read returns 0.
  - 0x1C RX_DATA: read returns the FIFO head, or 0 when empty.
  - 0x20 STATUS: bit0 tx_full, bit1 rx_nonempty, bit2 rx_ovf, bit3 tx_empty, [23:16] rx_count, [31:24] tx_count.
  - 0x24 IRQ_STAT, read-only: [N_TIMERS-1:0] timer flags, bit N rx_pend, bit N+1 tx_pend.
  - 0x28 UART_CTRL: bit0 rx_ie, bit1 tx_ie, bit2 flush (write-only, self-clearing).
  - Unmapped addresses read 0; writes to them are ignored.
- Reads: rdata is combinational from rd/addr and is 0 when rd=0.
  - A read of RX_DATA with the FIFO non-empty pops at the next clk edge.
  - A read of STATUS clears rx_ovf at the edge.
- Writes: registered at the clk edge when wr=1. Registers narrower than 32 bits take the low bits of wdata and read back zero-extended.
- Timer i, when TCON[0]=1, acts each cycle:
  - If TL equals all-ones: TL<=TH, and if TCON[1]=1 then TCON[2]<=1.
  - Otherwise TL<=TL+1.
  - TCON[2] is sticky; it clears only by a TCON write.
  - A bus write to TL or TCON in the same cycle as an overflow wins over the timer update.
- TX FIFO:
  - Push on a TX_DATA write when not full. A write when full is dropped.
  - Pop when tx_valid && tx_ready. tx_data is the FIFO head.
  - Push and pop in the same cycle when full is allowed: the pop frees an entry first.
- RX FIFO:
  - Push on rx_valid. If the FIFO is full, the byte is dropped and rx_ovf<=1.
  - Push and pop in the same cycle keep the count unchanged, including when full (no overflow).
- Flush: empties both FIFOs at the edge. A flush in the same cycle as a push or pop wins over them.
- Counts: 0..FIFO_DEPTH, zero-extended into 8 bits.
- Interrupts:
  - rx_pend = rx_ie & rx_nonempty.
  - tx_pend = tx_ie & tx_empty.
  - irqout = OR of the timer TCON[2] flags | rx_pend | tx_pend, registered (one cycle after the cause).
- Reset mid-transfer: FIFO contents are discarded; tx_valid drops asynchronously with reset.

Decomposition:
- periph_pkg: base address, all register offsets, timer stride, STATUS/IRQ_STAT/UART_CTRL bit positions.
- Sub-module: periph_fifo (8-bit synchronous FIFO, DEPTH parameter; push, pop, flush, full, empty, count). It is instantiated twice.
- Timer channels are built with a generate loop in the top module.

Test Plan:
- Timer: TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3 → TL reloads to 0xFFFFFFFD after 2 cycles; TCON reads 7; irqout=1 one cycle later; writing TCON=0 → irqout=0.
- TX FIFO with tx_ready=0:
  - 17 TX_DATA writes 0x00..0x10 → tx_full=1 and tx_count=16; byte 0x10 is dropped.
  - Raise tx_ready → bytes 0x00..0x0F appear on tx_data in order, then tx_valid=0 and tx_empty=1.
- RX overflow: 17 rx_valid pulses with no reads → rx_count=16 and rx_ovf=1. A STATUS read returns bit2=1; the next STATUS read returns bit2=0. Sixteen RX_DATA reads return the bytes in order, then 0.
- Same-cycle RX push and pop at full → rx_count stays 16 and rx_ovf stays 0.
- Interrupts: rx_ie=1 with one rx byte → irqout=1 and IRQ_STAT bit N=1. Popping the byte → irqout=0.
- Reset and flush:
  - Reset asserted mid-stream with 5 TX bytes queued → tx_valid=0 immediately; after release tx_count=0, led=0 and digi=0.
  - Flush with both FIFOs half full → both counts 0 next cycle.
